// File: rtl/pc_gen_pkg.sv
// Shared types, default vectors and helpers for the fetch PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcg_state_t;

  localparam logic [31:0] DefResetVector = 32'h0000_0000;
  localparam logic [31:0] DefTrapVector  = 32'h0000_0100;

  // True when addr is a multiple of ialign (ialign must be a power of two).
  function automatic logic is_aligned(input logic [63:0] addr, input int unsigned ialign);
    logic [63:0] mask;
    mask = 64'(ialign) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/pc_gen_unit_adder.sv
// Kogge-Stone carry-lookahead adder computing a_i + INC with carry-out.
module pc_inc_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INC   = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam logic [WIDTH-1:0] IncOp = WIDTH'(INC);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] grp_g;
  logic [WIDTH-1:0] grp_p;

  // Parallel-prefix carry tree; after the loop grp_g[i] is the generate of bits [i:0].
  always_comb begin
    gen   = a_i & IncOp;
    prop  = a_i ^ IncOp;
    grp_g = gen;
    grp_p = prop;
    for (int unsigned d = 1; d < WIDTH; d = d << 1) begin
      // Descending order lets the span double in place without a second buffer.
      for (int unsigned i = WIDTH - 1; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
  end

  assign sum_o  = prop ^ {grp_g[WIDTH-2:0], 1'b0};
  assign cout_o = grp_g[WIDTH-1];

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch program-counter generator: BOOT/RUN/HALT control, redirects with
// alignment trapping, sequential advance with wrap detection, advance counter.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      IALIGN       = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DefResetVector),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DefTrapVector),
  parameter int unsigned      CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [WIDTH-1:0]     pc,
  output logic                 pc_valid,
  output logic [WIDTH-1:0]     pc_plus_inc,
  output logic                 misalign_err,
  output logic                 wrap_flag,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  pcg_state_t           state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 misalign_q, misalign_d;
  logic                 wrap_q, wrap_d;

  logic [WIDTH-1:0] seq_pc;
  logic             seq_cout;
  logic             target_ok;

  pc_inc_adder #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_adder (
    .a_i    (pc_q),
    .sum_o  (seq_pc),
    .cout_o (seq_cout)
  );

  assign target_ok = is_aligned(64'(redirect_target), IALIGN);

  // Next-state logic: redirect > stall > sequential advance; halt_req applies on top.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    wrap_d     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = target_ok ? redirect_target : TRAP_VECTOR;
          misalign_d = ~target_ok;
          cnt_d      = cnt_q + CNT_WIDTH'(1);
        end else if (!stall) begin
          pc_d   = seq_pc;
          wrap_d = seq_cout;
          cnt_d  = cnt_q + CNT_WIDTH'(1);
        end
        if (halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        // Redirects still land while halted but are not counted as fetch advances.
        if (redirect_valid) begin
          pc_d       = target_ok ? redirect_target : TRAP_VECTOR;
          misalign_d = ~target_ok;
        end
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      wrap_q     <= wrap_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus_inc  = seq_pc;
  assign pc_valid     = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;
  assign wrap_flag    = wrap_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit with a behavioural reference model.
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_plus_inc;
  logic        misalign_err;
  logic        wrap_flag;
  logic        halted;
  logic [15:0] fetch_count;

  int checks;
  int failures;

  // Reference model: plain arithmetic over the architectural rules.
  bit          m_boot;
  bit          m_run;
  bit          m_halt;
  logic [31:0] m_pc;
  int unsigned m_cnt;
  bit          m_mis;
  bit          m_wrap;

  pc_gen_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_plus_inc     (pc_plus_inc),
    .misalign_err    (misalign_err),
    .wrap_flag       (wrap_flag),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_boot = 1'b1;
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_pc   = 32'h0;
    m_cnt  = 0;
    m_mis  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_redirect(input logic [31:0] tgt);
    if (tgt % 4 != 0) begin
      m_pc  = 32'h100;
      m_mis = 1'b1;
    end else begin
      m_pc = tgt;
    end
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] tgt,
                            input logic hr, input logic rs);
    longint nxt;
    m_mis  = 1'b0;
    m_wrap = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      m_run  = 1'b1;
    end else if (m_run) begin
      if (rv) begin
        model_redirect(tgt);
        m_cnt = (m_cnt + 1) % 65536;
      end else if (!s) begin
        nxt    = longint'(m_pc) + 4;
        m_wrap = (nxt >= 64'h1_0000_0000);
        m_pc   = 32'(nxt % 64'h1_0000_0000);
        m_cnt  = (m_cnt + 1) % 65536;
      end
      if (hr) begin
        m_run  = 1'b0;
        m_halt = 1'b1;
      end
    end else if (m_halt) begin
      if (rv) model_redirect(tgt);
      if (rs) begin
        m_halt = 1'b0;
        m_run  = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs from a negedge, advance the model at the posedge.
  task automatic step(input logic s, input logic rv, input logic [31:0] tgt,
                      input logic hr, input logic rs);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    halt_req        = hr;
    resume          = rs;
    @(posedge clk);
    model_edge(s, rv, tgt, hr, rs);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0; resume = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0 ||
        misalign_err !== 1'b0 || wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual pc=%h v=%b h=%b cnt=%0d mis=%b wr=%b required all zero",
               pc, pc_valid, halted, fetch_count, misalign_err, wrap_flag);
    end
    rst = 1'b0;
    checks++;
    if (pc_valid !== 1'b0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL boot_cycle actual pc=%h v=%b required pc=0 v=0", pc, pc_valid);
    end
    // BOOT ignores inputs, so a redirect here must have no effect.
    step(1'b0, 1'b1, 32'h0000_0800, 1'b1, 1'b0);
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b1 || halted !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL boot_exit actual pc=%h v=%b h=%b cnt=%0d required pc=0 v=1 h=0 cnt=0",
               pc, pc_valid, halted, fetch_count);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (pc !== 32'(4 * i) || pc_plus_inc !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL seq_advance actual pc=%h plus=%h required pc=%h plus=%h",
                 pc, pc_plus_inc, 32'(4 * i), 32'(4 * i + 4));
      end
    end
    checks++;
    if (fetch_count !== 16'd3) begin
      failures++;
      $display("FAIL count_after_3 actual=%0d required=3", fetch_count);
    end
  endtask

  task automatic test_stall_redirect();
    logic [15:0] c0;
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    c0 = 16'(m_cnt);
    repeat (2) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (pc !== 32'h10 || fetch_count !== c0) begin
        failures++;
        $display("FAIL stall_hold actual pc=%h cnt=%0d required pc=10 cnt=%0d",
                 pc, fetch_count, c0);
      end
    end
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h200 || fetch_count !== c0 + 16'd1) begin
      failures++;
      $display("FAIL redirect_over_stall actual pc=%h cnt=%0d required pc=200 cnt=%0d",
               pc, fetch_count, c0 + 16'd1);
    end
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h100 || misalign_err !== 1'b1) begin
      failures++;
      $display("FAIL misalign_trap actual pc=%h mis=%b required pc=100 mis=1", pc, misalign_err);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (misalign_err !== 1'b0 || pc !== 32'h100) begin
      failures++;
      $display("FAIL misalign_pulse actual pc=%h mis=%b required pc=100 mis=0", pc, misalign_err);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc_plus_inc !== 32'h0 || wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL wrap_setup actual pc=%h plus=%h wr=%b required pc=fffffffc plus=0 wr=0",
               pc, pc_plus_inc, wrap_flag);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0 || wrap_flag !== 1'b1) begin
      failures++;
      $display("FAIL wrap_event actual pc=%h wr=%b required pc=0 wr=1", pc, wrap_flag);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h4 || wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pulse actual pc=%h wr=%b required pc=4 wr=0", pc, wrap_flag);
    end
  endtask

  task automatic test_halt_resume();
    logic [15:0] c0;
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    c0 = 16'(m_cnt);
    checks++;
    if (pc !== 32'h44 || halted !== 1'b1 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_entry actual pc=%h h=%b v=%b required pc=44 h=1 v=0",
               pc, halted, pc_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (pc !== 32'h44 || halted !== 1'b1 || fetch_count !== c0) begin
      failures++;
      $display("FAIL halt_hold actual pc=%h h=%b cnt=%0d required pc=44 h=1 cnt=%0d",
               pc, halted, fetch_count, c0);
    end
    step(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h80 || fetch_count !== c0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_redirect actual pc=%h cnt=%0d h=%b required pc=80 cnt=%0d h=1",
               pc, fetch_count, halted, c0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (pc !== 32'h80 || halted !== 1'b0 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL resume actual pc=%h h=%b v=%b required pc=80 h=0 v=1", pc, halted, pc_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h84 || fetch_count !== c0 + 16'd1) begin
      failures++;
      $display("FAIL resume_advance actual pc=%h cnt=%0d required pc=84 cnt=%0d",
               pc, fetch_count, c0 + 16'd1);
    end
    // halt_req beats resume in RUN; the advance on that edge still happens.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (pc !== 32'h88 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_wins actual pc=%h h=%b required pc=88 h=1", pc, halted);
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (pc !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0 || fetch_count !== 16'd0 ||
        misalign_err !== 1'b0 || wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual pc=%h h=%b v=%b cnt=%0d mis=%b wr=%b required zeros",
               pc, halted, pc_valid, fetch_count, misalign_err, wrap_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pc_valid !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reboot_cycle actual v=%b h=%b required v=0 h=0", pc_valid, halted);
    end
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b1 || halted !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL reboot_exit actual pc=%h v=%b h=%b cnt=%0d required pc=0 v=1 h=0 cnt=0",
               pc, pc_valid, halted, fetch_count);
    end
  endtask

  task automatic test_random();
    logic        s, rv, hr, rs;
    logic [31:0] tgt;
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 99) < 20);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom() & 32'hFFFF_FFFC;
        1:       tgt = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        2:       tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        default: tgt = 32'(4 * $urandom_range(0, 255));
      endcase
      s  = ($urandom_range(0, 3) == 0);
      hr = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 3) == 0);
      step(s, rv, tgt, hr, rs);
      checks++;
      if (pc !== m_pc || pc_plus_inc !== m_pc + 32'd4) begin
        failures++;
        $display("FAIL rand_pc n=%0d actual pc=%h plus=%h required pc=%h plus=%h",
                 n, pc, pc_plus_inc, m_pc, m_pc + 32'd4);
      end
      checks++;
      if (pc_valid !== m_run || halted !== m_halt) begin
        failures++;
        $display("FAIL rand_state n=%0d actual v=%b h=%b required v=%b h=%b",
                 n, pc_valid, halted, m_run, m_halt);
      end
      checks++;
      if (fetch_count !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rand_count n=%0d actual=%0d required=%0d", n, fetch_count, m_cnt);
      end
      checks++;
      if (misalign_err !== m_mis || wrap_flag !== m_wrap) begin
        failures++;
        $display("FAIL rand_pulses n=%0d actual mis=%b wr=%b required mis=%b wr=%b",
                 n, misalign_err, wrap_flag, m_mis, m_wrap);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stall_redirect();
    test_misalign();
    test_wrap();
    test_halt_resume();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
